// File: rtl/interp_buffer_sequencer_pkg.sv
// Shared definitions for the 2nd-pass row buffer sequencer: default
// geometry of the 9 x 165-bit row bank and the two-phase state encoding.
package interp_buffer_sequencer_pkg;

  // Rows per block (N+T-1); number of bank entries used.
  localparam int unsigned DEF_DEPTH  = 9;
  // Row width in bits: packed signed samples, never inspected here.
  localparam int unsigned DEF_DATA_W = 165;
  // Bank address width; 2**DEF_ADDR_W must cover DEF_DEPTH entries.
  localparam int unsigned DEF_ADDR_W = 4;
  // Index of the final row in a block.
  localparam int unsigned LAST       = DEF_DEPTH - 1;

  // FILL writes 1st-pass rows into the bank, DRAIN reads them back out.
  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/interp_buffer_sequencer.sv
// Control end of the 2nd-pass row buffer. Writes one block of DEPTH rows
// into the bank at addresses 0..DEPTH-1, then reads them back in order and
// hands them to the 2nd pass over a valid/ready handshake. The bank has a
// 1-cycle registered read that holds its value while no read is issued, so
// the output row stays stable under backpressure without a local copy.
module interp_buffer_sequencer
  import interp_buffer_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_async_n_i,
  input  logic [DATA_W-1:0] row_in_i,
  input  logic              row_in_valid_i,
  output logic              row_in_ready_o,
  output logic [ADDR_W-1:0] buf_addr_sel_o,
  output logic [DATA_W-1:0] buf_data_in_o,
  output logic              buf_write_en_o,
  output logic              buf_read_en_o,
  input  logic [DATA_W-1:0] buf_data_out_i,
  output logic [DATA_W-1:0] row_out_o,
  output logic              row_out_valid_o,
  input  logic              row_out_ready_i,
  output logic              block_done_o
);

  // The read counter must reach DEPTH itself ("all reads issued"), so it
  // carries one extra bit beyond the bank address.
  localparam int unsigned       CNT_W   = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] WR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] WR_ONE  = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  RD_END  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  RD_ONE  = CNT_W'(1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic                out_valid_q, out_valid_d;
  // Low during reset and for the first edge after it, so the input side
  // reports not-ready until reset has really been released.
  logic                live_q;

  logic                in_ready_s;
  logic                write_s;
  logic                issue_s;
  logic                xfer_s;
  logic                done_s;
  logic [ADDR_W-1:0]   addr_s;

  // Next-state, counter and strobe decode for both phases.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    out_valid_d = out_valid_q;
    in_ready_s  = 1'b0;
    write_s     = 1'b0;
    issue_s     = 1'b0;
    xfer_s      = 1'b0;
    done_s      = 1'b0;
    addr_s      = {ADDR_W{1'b0}};

    case (state_q)
      ST_FILL: begin
        in_ready_s = live_q;
        if (live_q && row_in_valid_i) begin
          write_s = 1'b1;
          addr_s  = wr_cnt_q;
          if (wr_cnt_q == WR_LAST) begin
            wr_cnt_d = {ADDR_W{1'b0}};
            state_d  = ST_DRAIN;
          end else begin
            wr_cnt_d = wr_cnt_q + WR_ONE;
          end
        end else begin
          wr_cnt_d = wr_cnt_q;
        end
      end

      ST_DRAIN: begin
        // Only read when the output slot is empty or being emptied, so the
        // bank read register is never overwritten under a stalled row.
        xfer_s      = out_valid_q & row_out_ready_i;
        issue_s     = (rd_cnt_q < RD_END) && (!out_valid_q || row_out_ready_i);
        out_valid_d = issue_s | (out_valid_q & ~row_out_ready_i);
        if (issue_s) begin
          addr_s   = rd_cnt_q[ADDR_W-1:0];
          rd_cnt_d = rd_cnt_q + RD_ONE;
        end else if (xfer_s && (rd_cnt_q == RD_END)) begin
          // Last row leaves this cycle; refill only starts next cycle.
          done_s   = 1'b1;
          rd_cnt_d = {CNT_W{1'b0}};
          state_d  = ST_FILL;
        end else begin
          rd_cnt_d = rd_cnt_q;
        end
      end

      default: begin
        state_d     = ST_FILL;
        wr_cnt_d    = {ADDR_W{1'b0}};
        rd_cnt_d    = {CNT_W{1'b0}};
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State, counters and output-valid flag; reset discards any partial block.
  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      state_q     <= ST_FILL;
      wr_cnt_q    <= {ADDR_W{1'b0}};
      rd_cnt_q    <= {CNT_W{1'b0}};
      out_valid_q <= 1'b0;
      live_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      out_valid_q <= out_valid_d;
      live_q      <= 1'b1;
    end
  end

  assign row_in_ready_o  = in_ready_s;
  assign buf_addr_sel_o  = addr_s;
  assign buf_data_in_o   = row_in_i;
  assign buf_write_en_o  = write_s;
  assign buf_read_en_o   = issue_s;
  assign row_out_o       = buf_data_out_i;
  assign row_out_valid_o = out_valid_q;
  assign block_done_o    = done_s;

endmodule

// File: tb/tb_interp_buffer_sequencer.sv
// Bench for interp_buffer_sequencer together with a behavioural model of the
// 9-entry row bank (write priority, registered read, unreset read register).
module tb_interp_buffer_sequencer;

  localparam int DW = 165;
  localparam int AW = 4;
  localparam int NROWS = 9;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] row_in;
  logic          row_in_valid;
  logic          row_in_ready;
  logic [AW-1:0] addr;
  logic [DW-1:0] bdin;
  logic          we;
  logic          re;
  logic [DW-1:0] bdout;
  logic [DW-1:0] row_out;
  logic          row_out_valid;
  logic          row_out_ready;
  logic          done;

  int n_vec = 0;
  int n_err = 0;

  interp_buffer_sequencer dut (
    .clk_i           (clk),
    .rst_async_n_i   (rst_n),
    .row_in_i        (row_in),
    .row_in_valid_i  (row_in_valid),
    .row_in_ready_o  (row_in_ready),
    .buf_addr_sel_o  (addr),
    .buf_data_in_o   (bdin),
    .buf_write_en_o  (we),
    .buf_read_en_o   (re),
    .buf_data_out_i  (bdout),
    .row_out_o       (row_out),
    .row_out_valid_o (row_out_valid),
    .row_out_ready_i (row_out_ready),
    .block_done_o    (done)
  );

  // Bank model: write wins over read; read data held when not reading.
  logic [DW-1:0] mem [0:NROWS-1];
  always @(posedge clk) begin
    if (we) begin
      if (addr < AW'(NROWS)) mem[addr] <= bdin;
    end else if (re) begin
      if (addr < AW'(NROWS)) bdout <= mem[addr];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          vin;
    logic [DW-1:0] din;
    logic          ordy;
    logic          e_irdy;
    logic          e_we;
    logic          e_re;
    logic [AW-1:0] e_addr;
    logic          e_ov;
    logic [DW-1:0] e_dout;
    logic          e_done;
  } vec_t;

  vec_t vecs [20];

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic chka(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chkd(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input int i);
    row_in_valid  = vecs[i].vin;
    row_in        = vecs[i].din;
    row_out_ready = vecs[i].ordy;
    @(negedge clk);
    chk1($sformatf("vec%0d.in_ready", i), row_in_ready, vecs[i].e_irdy);
    chk1($sformatf("vec%0d.write_en", i), we, vecs[i].e_we);
    chk1($sformatf("vec%0d.read_en", i), re, vecs[i].e_re);
    chka($sformatf("vec%0d.addr", i), addr, vecs[i].e_addr);
    chk1($sformatf("vec%0d.out_valid", i), row_out_valid, vecs[i].e_ov);
    if (vecs[i].e_ov) chkd($sformatf("vec%0d.row_out", i), row_out, vecs[i].e_dout);
    chk1($sformatf("vec%0d.done", i), done, vecs[i].e_done);
    tick();
  endtask

  // Writes rows base..base+8; gap=3 offers a row on one cycle in three.
  task automatic fill_block(input int base, input int gap);
    int k = 0;
    int cyc = 0;
    while (k < NROWS && cyc < 100) begin
      row_in_valid  = ((cyc % gap) == 0);
      row_in        = DW'(base + k);
      row_out_ready = 1'b1;
      @(negedge clk);
      chk1("fill.in_ready", row_in_ready, 1'b1);
      chk1("fill.write_en", we, row_in_valid);
      chk1("fill.read_en", re, 1'b0);
      chka("fill.addr", addr, row_in_valid ? AW'(k) : AW'(0));
      chk1("fill.out_valid", row_out_valid, 1'b0);
      if (row_in_valid) begin
        chkd("fill.data_in", bdin, DW'(base + k));
        k++;
      end
      tick();
      cyc++;
    end
    chk1("fill.complete", (k == NROWS), 1'b1);
    row_in_valid = 1'b0;
  endtask

  // Drains one block expecting rows base..base+8. stall holds ready low for
  // 4 cycles on the 3rd and 7th rows; junk offers 0xDEAD on the input side;
  // stop_after>0 returns right after that many transfers.
  task automatic drain_block(input int base, input bit stall, input bit junk, input int stop_after);
    int  k_rd = 0;
    int  k_tr = 0;
    int  hold_cnt = 0;
    int  cyc = 0;
    bit  fin = 1'b0;
    bit  hold;
    while (!fin && cyc < 60) begin
      hold = stall && row_out_valid && (k_tr == 2 || k_tr == 6) && (hold_cnt < 4);
      if (hold) hold_cnt++;
      row_out_ready = !hold;
      row_in_valid  = junk;
      row_in        = DW'(32'hDEAD);
      @(negedge clk);
      chk1("drain.in_ready", row_in_ready, 1'b0);
      chk1("drain.write_en", we, 1'b0);
      if (re) begin
        chka("drain.rd_addr", addr, AW'(k_rd));
        k_rd++;
      end else begin
        chka("drain.idle_addr", addr, AW'(0));
      end
      if (hold) chk1("drain.no_read_stalled", re, 1'b0);
      if (row_out_valid) chkd("drain.row_out", row_out, DW'(base + k_tr));
      if (row_out_valid && row_out_ready) begin
        chk1("drain.done", done, (k_tr == NROWS - 1));
        if (k_tr == NROWS - 1) fin = 1'b1;
        k_tr++;
        hold_cnt = 0;
        if (stop_after > 0 && k_tr == stop_after) fin = 1'b1;
      end else begin
        chk1("drain.done_idle", done, 1'b0);
      end
      tick();
      cyc++;
    end
    row_in_valid  = 1'b0;
    row_out_ready = 1'b1;
    if (stop_after == 0) begin
      chka("drain.transfers", AW'(k_tr), AW'(NROWS));
      chka("drain.reads", AW'(k_rd), AW'(NROWS));
      @(negedge clk);
      chk1("drain.ready_after", row_in_ready, 1'b1);
      chk1("drain.valid_after", row_out_valid, 1'b0);
      tick();
    end
  endtask

  initial begin
    // Streaming block: 9 writes, one lead-in read, 9 outputs, then refill.
    for (int i = 0; i < 20; i++) begin
      vecs[i] = '{vin: 1'b0, din: '0, ordy: 1'b1, e_irdy: 1'b0, e_we: 1'b0,
                  e_re: 1'b0, e_addr: '0, e_ov: 1'b0, e_dout: '0, e_done: 1'b0};
    end
    for (int i = 0; i < 9; i++) begin
      vecs[i].vin    = 1'b1;
      vecs[i].din    = DW'(i + 1);
      vecs[i].e_irdy = 1'b1;
      vecs[i].e_we   = 1'b1;
      vecs[i].e_addr = AW'(i);
    end
    vecs[9].e_re = 1'b1;
    for (int i = 10; i < 18; i++) begin
      vecs[i].e_re   = 1'b1;
      vecs[i].e_addr = AW'(i - 9);
      vecs[i].e_ov   = 1'b1;
      vecs[i].e_dout = DW'(i - 9);
    end
    vecs[18].e_ov   = 1'b1;
    vecs[18].e_dout = DW'(9);
    vecs[18].e_done = 1'b1;
    vecs[19].e_irdy = 1'b1;

    // Reset: inputs active but nothing may be accepted or strobed.
    rst_n         = 1'b0;
    row_in_valid  = 1'b1;
    row_in        = DW'(32'h55);
    row_out_ready = 1'b1;
    #3;
    for (int r = 0; r < 2; r++) begin
      chk1("rst.in_ready", row_in_ready, 1'b0);
      chk1("rst.write_en", we, 1'b0);
      chk1("rst.read_en", re, 1'b0);
      chka("rst.addr", addr, AW'(0));
      chk1("rst.out_valid", row_out_valid, 1'b0);
      chk1("rst.done", done, 1'b0);
      tick();
    end
    row_in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk1("post_rst.in_ready", row_in_ready, 1'b1);
    tick();

    for (int i = 0; i < 20; i++) apply_vec(i);

    // Backpressure on rows 3 and 7.
    fill_block(1, 1);
    drain_block(1, 1'b1, 1'b0, 0);

    // Gapped input, junk offered during drain, then the next block.
    fill_block(1, 3);
    drain_block(1, 1'b0, 1'b1, 0);
    fill_block(10, 1);
    drain_block(10, 1'b0, 1'b1, 0);

    // Reset after the 4th transfer of a block.
    fill_block(48, 1);
    drain_block(48, 1'b0, 1'b0, 4);
    chk1("mid.valid_before", row_out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("mid.valid_cleared", row_out_valid, 1'b0);
    chk1("mid.in_ready", row_in_ready, 1'b0);
    chk1("mid.read_en", re, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    fill_block(64, 1);
    drain_block(64, 1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
